// File: rtl/biriscv_tres_pkg.sv
// Shared types and constants for the test-result mailbox: FSM states,
// the passing-signature prefix and the verdict words.
package biriscv_tres_pkg;

    typedef enum logic [1:0] {
        TRES_COLLECT,
        TRES_DUMP,
        TRES_DONE
    } tres_state_t;

    localparam logic [15:0] TRES_SIG_PREFIX   = 16'h600D;
    localparam logic [31:0] TRES_VERDICT_PASS = 32'h600D_600D;
    localparam logic [15:0] TRES_VERDICT_FAIL = 16'hBAD0;

endpackage

// File: rtl/biriscv_tres_popcount.sv
// Combinational population count of the per-test pass vector.
module biriscv_tres_popcount #(
    parameter int WIDTH   = 10,
    parameter int COUNT_W = 8
) (
    input  logic [WIDTH-1:0]   bits,
    output logic [COUNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + COUNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/biriscv_test_result_mailbox.sv
// Store-path mailbox that grades test signatures as they are written and,
// on completion, streams every slot followed by a verdict word.
module biriscv_test_result_mailbox
    import biriscv_tres_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_9000,
    parameter int          NUM_SLOTS  = 12,
    parameter logic [15:0] SIG_PREFIX = TRES_SIG_PREFIX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    output logic        wr_ready_o,
    input  logic        done_i,
    output logic        out_valid_o,
    output logic [31:0] out_data_o,
    output logic        out_last_o,
    input  logic        out_ready_i,
    output logic [7:0]  pass_count_o,
    output logic        all_pass_o,
    output logic        busy_o
);

    localparam int NUM_TESTS = NUM_SLOTS - 2;
    localparam int SLOT_W    = $clog2(NUM_SLOTS);
    localparam int IDX_W     = $clog2(NUM_SLOTS + 1);

    tres_state_t          state;
    logic [31:0]          slot     [NUM_SLOTS];
    logic [31:0]          slot_rd  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] written;
    logic [NUM_TESTS-1:0] pass;
    logic [NUM_TESTS-1:0] fail_mask;
    logic [IDX_W-1:0]     word_idx;
    logic [IDX_W-1:0]     next_idx;
    logic [31:0]          next_word;
    logic [31:0]          verdict;
    logic [31:0]          wr_offset;
    logic [SLOT_W-1:0]    wr_slot;
    logic                 wr_hit;
    logic                 wr_accept;
    logic [7:0]           pop_count;

    // Unsigned subtraction makes addresses below the base wrap to huge
    // offsets, so one compare covers both window bounds.
    assign wr_offset  = wr_addr_i - BASE_ADDR;
    assign wr_hit     = (wr_offset < 32'(4 * NUM_SLOTS)) && (wr_offset[1:0] == 2'b00);
    assign wr_slot    = wr_offset[SLOT_W+1:2];
    assign wr_ready_o = (state != TRES_DUMP);
    assign wr_accept  = wr_valid_i && wr_ready_o && wr_hit && (state == TRES_COLLECT);

    always_comb begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_rd[k] = written[k] ? slot[k] : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot[k] <= '0;
            end
            written <= '0;
            pass    <= '0;
        end else if (wr_accept) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (wr_slot == SLOT_W'(k)) begin
                    slot[k]    <= wr_data_i;
                    written[k] <= 1'b1;
                end
            end
            for (int k = 0; k < NUM_TESTS; k++) begin
                if (wr_slot == SLOT_W'(k)) begin
                    pass[k] <= (wr_data_i == {SIG_PREFIX, 16'(k + 1)});
                end
            end
        end
    end

    biriscv_tres_popcount #(
        .WIDTH   (NUM_TESTS),
        .COUNT_W (8)
    ) u_popcount (
        .bits  (pass),
        .count (pop_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_count_o <= '0;
            all_pass_o   <= 1'b0;
        end else begin
            pass_count_o <= pop_count;
            all_pass_o   <= (pop_count == 8'(NUM_TESTS))
                         && (slot_rd[NUM_SLOTS-2] == 32'(NUM_TESTS))
                         && (slot_rd[NUM_SLOTS-1] == 32'(NUM_TESTS));
        end
    end

    assign fail_mask = ~pass;
    assign verdict   = all_pass_o ? TRES_VERDICT_PASS : {TRES_VERDICT_FAIL, 16'(fail_mask)};
    assign next_idx  = word_idx + IDX_W'(1);

    always_comb begin
        next_word = verdict;
        if (next_idx < IDX_W'(NUM_SLOTS)) begin
            next_word = slot_rd[next_idx[SLOT_W-1:0]];
        end
    end

    // Slot 0 bypasses storage so a store landing with done_i is still dumped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= TRES_COLLECT;
            word_idx    <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            out_data_o  <= '0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                TRES_COLLECT: begin
                    if (done_i) begin
                        state       <= TRES_DUMP;
                        busy_o      <= 1'b1;
                        out_valid_o <= 1'b1;
                        out_last_o  <= 1'b0;
                        word_idx    <= '0;
                        out_data_o  <= (wr_accept && wr_slot == '0) ? wr_data_i : slot_rd[0];
                    end
                end
                TRES_DUMP: begin
                    if (out_ready_i) begin
                        if (out_last_o) begin
                            state       <= TRES_DONE;
                            busy_o      <= 1'b0;
                            out_valid_o <= 1'b0;
                            out_last_o  <= 1'b0;
                            out_data_o  <= '0;
                        end else begin
                            word_idx   <= next_idx;
                            out_data_o <= next_word;
                            out_last_o <= (next_idx == IDX_W'(NUM_SLOTS));
                        end
                    end
                end
                TRES_DONE: begin
                    state <= TRES_DONE;
                end
                default: begin
                    state <= TRES_COLLECT;
                end
            endcase
        end
    end

endmodule
